// File: rtl/glm_stream_fifo_pkg.sv
// glm_stream_fifo_pkg: shared constants, push-side structs and helpers for the GLM stream FIFOs
package glm_stream_fifo_pkg;
   localparam int GLM_PREFETCH_SIZE = 16;
   localparam int GLM_AFULL_MARGIN  = GLM_PREFETCH_SIZE;
   localparam int GLM_CL_WIDTH      = 512;
   localparam int GLM_WORD_WIDTH    = 32;
   typedef struct packed {
      logic                      we;
      logic [GLM_WORD_WIDTH-1:0] wdata;
   } wordfifo_in_t;
   typedef struct packed {
      logic                    we;
      logic [GLM_CL_WIDTH-1:0] wdata;
   } clfifo_in_t;
   function automatic int afull_threshold(input int log2_depth, input int margin);
      return (2 ** log2_depth) - margin;
   endfunction
endpackage

// File: rtl/glm_sdp_bram.sv
// glm_sdp_bram: simple dual-port RAM, registered 1-cycle read, no read-during-write forwarding
module glm_sdp_bram #(
   parameter int WIDTH      = 512,
   parameter int LOG2_DEPTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LOG2_DEPTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   input  logic [LOG2_DEPTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);
   logic [WIDTH-1:0] mem [2**LOG2_DEPTH];
   // write port and registered read port; the caller never reads the address being written
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/glm_stream_fifo.sv
// glm_stream_fifo: FWFT FIFO with AXI-stream pop side, flush, almost-full margin and sticky overflow
module glm_stream_fifo
   import glm_stream_fifo_pkg::*;
#(
   parameter int WIDTH        = 512,
   parameter int LOG2_DEPTH   = 10,
   parameter int AFULL_MARGIN = GLM_AFULL_MARGIN
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  we,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      re_tdata,
   output logic                  re_tvalid,
   input  logic                  re_tready,
   output logic                  almostfull,
   output logic [LOG2_DEPTH:0]   count,
   output logic                  overflow
);
   localparam int CW    = LOG2_DEPTH + 1;
   localparam int DEPTH = 2 ** LOG2_DEPTH;
   logic [LOG2_DEPTH-1:0] wptr, rptr;
   logic [WIDTH-1:0]      o_d, ram_q;
   logic                  o_v, r_v;
   logic                  clr, full, push, pop, o_keep, r_keep, rd;
   logic [CW-1:0]         held;
   // the skid is the output register (older) plus the BRAM read register (younger)
   assign clr        = reset | flush;
   assign full       = count == CW'(DEPTH);
   assign push       = we & ~full;
   assign re_tvalid  = o_v | r_v;
   assign re_tdata   = o_v ? o_d : ram_q;
   assign pop        = re_tvalid & re_tready;
   assign o_keep     = o_v & ~pop;
   assign r_keep     = r_v & ~(pop & ~o_v);
   assign held       = CW'(o_v) + CW'(r_v);
   assign rd         = (count > held) & ~(o_keep & r_keep);
   assign almostfull = count >= CW'(afull_threshold(LOG2_DEPTH, AFULL_MARGIN));
   glm_sdp_bram #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_ram (
      .clk   (clk),
      .we    (push & ~clr),
      .waddr (wptr),
      .wdata (wdata),
      .re    (rd & ~clr),
      .raddr (rptr),
      .rdata (ram_q)
   );
   // pointers, occupancy, skid valids and the sticky overflow flag
   always_ff @(posedge clk) begin
      if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         o_v   <= 1'b0;
         r_v   <= 1'b0;
         if (reset) overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         o_v   <= o_keep | (rd & r_keep);
         r_v   <= r_keep | rd;
         if (we & full) overflow <= 1'b1;
      end
   end
   // a new read would overwrite an unconsumed BRAM word, so move it into the output register first
   always_ff @(posedge clk) begin
      if (rd & r_keep) o_d <= ram_q;
   end
endmodule

// File: tb/tb_glm_stream_fifo.sv
// tb_glm_stream_fifo: randomized and directed checks of glm_stream_fifo against a queue model
module tb_glm_stream_fifo;
   localparam int W = 32, L = 4, M = 4, DEPTH = 16;
   logic clk = 0, reset = 0, flush = 0, we = 0, re_tready = 0;
   logic [W-1:0] wdata = '0, re_tdata;
   logic re_tvalid, almostfull, overflow;
   logic [L:0] count;
   int checks = 0, passes = 0;
   logic [W-1:0] m_q [$];
   logic m_ovf = 0;

   glm_stream_fifo #(.WIDTH(W), .LOG2_DEPTH(L), .AFULL_MARGIN(M)) dut (
      .clk(clk), .reset(reset), .flush(flush), .we(we), .wdata(wdata),
      .re_tdata(re_tdata), .re_tvalid(re_tvalid), .re_tready(re_tready),
      .almostfull(almostfull), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // one clock cycle: drive inputs at negedge, step the queue model, return at the next negedge
   task automatic go(input logic w, input logic [W-1:0] d, input logic r, input logic f,
                     output logic popped, output logic [W-1:0] act, output logic [W-1:0] exp);
      logic was_full;
      we = w; wdata = d; re_tready = r; flush = f;
      popped = re_tvalid & r & ~f & ~reset;
      act = re_tdata;
      exp = (m_q.size() > 0) ? m_q[0] : 'x;
      if (reset) begin
         m_q.delete(); m_ovf = 0;
      end else if (f) begin
         m_q.delete();
      end else begin
         was_full = m_q.size() == DEPTH;
         if (popped && m_q.size() > 0) void'(m_q.pop_front());
         if (w) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back(d);
         end
      end
      @(negedge clk);
      we = 0; re_tready = 0; flush = 0;
   endtask

   task automatic test_reset();
      logic p; logic [W-1:0] a, e;
      reset = 1;
      go(1, 32'h1234, 0, 0, p, a, e);
      go(1, 32'h5678, 0, 0, p, a, e);
      reset = 0;
      checks++; if (count !== 0) $display("FAIL reset_count got %0d want 0", count); else passes++;
      checks++; if (re_tvalid !== 0) $display("FAIL reset_tvalid got %b want 0", re_tvalid); else passes++;
      checks++; if (almostfull !== 0) $display("FAIL reset_afull got %b want 0", almostfull); else passes++;
      checks++; if (overflow !== 0) $display("FAIL reset_overflow got %b want 0", overflow); else passes++;
   endtask

   task automatic test_latency();
      logic p; logic [W-1:0] a, e;
      go(1, 32'hA, 0, 0, p, a, e);
      checks++; if (count !== 1) $display("FAIL lat_count_t1 got %0d want 1", count); else passes++;
      checks++; if (re_tvalid !== 0) $display("FAIL lat_tvalid_t1 got %b want 0", re_tvalid); else passes++;
      go(0, 0, 0, 0, p, a, e);
      checks++; if (re_tvalid !== 1) $display("FAIL lat_tvalid_t2 got %b want 1", re_tvalid); else passes++;
      checks++; if (re_tdata !== 32'hA) $display("FAIL lat_tdata_t2 got %h want a", re_tdata); else passes++;
      go(0, 0, 1, 0, p, a, e);
      checks++; if (!p || a !== e) $display("FAIL lat_pop got %b/%h want 1/%h", p, a, e); else passes++;
      checks++; if (count !== 0 || re_tvalid !== 0) $display("FAIL lat_empty got %0d/%b want 0/0", count, re_tvalid); else passes++;
   endtask

   task automatic test_fill();
      logic p; logic [W-1:0] a, e;
      for (int i = 0; i < DEPTH; i++) begin
         go(1, W'(i), 0, 0, p, a, e);
         checks++; if (count !== m_q.size()) $display("FAIL fill_count got %0d want %0d", count, m_q.size()); else passes++;
         checks++; if (almostfull !== (m_q.size() >= DEPTH - M)) $display("FAIL fill_afull at %0d got %b want %b", m_q.size(), almostfull, m_q.size() >= DEPTH - M); else passes++;
         checks++; if (overflow !== 0) $display("FAIL fill_overflow got %b want 0", overflow); else passes++;
      end
      go(1, 32'd99, 0, 0, p, a, e);
      checks++; if (overflow !== 1) $display("FAIL fill_drop_overflow got %b want 1", overflow); else passes++;
      checks++; if (count !== 16) $display("FAIL fill_drop_count got %0d want 16", count); else passes++;
      checks++; if (almostfull !== 1) $display("FAIL fill_drop_afull got %b want 1", almostfull); else passes++;
   endtask

   task automatic test_drain();
      logic p; logic [W-1:0] a, e;
      int j = 0;
      for (int c = 0; c < 40; c++) begin
         go(0, 0, 1, 0, p, a, e);
         if (p) begin
            checks++; if (a !== e || a !== W'(j)) $display("FAIL drain_data got %h want %h", a, j); else passes++;
            j++;
         end
      end
      checks++; if (j !== 16) $display("FAIL drain_pops got %0d want 16", j); else passes++;
      checks++; if (re_tvalid !== 0 || count !== 0) $display("FAIL drain_empty got %b/%0d want 0/0", re_tvalid, count); else passes++;
      checks++; if (overflow !== m_ovf) $display("FAIL drain_overflow got %b want %b", overflow, m_ovf); else passes++;
   endtask

   task automatic test_back_to_back();
      logic p; logic [W-1:0] a, e;
      for (int i = 0; i < 8; i++) go(1, 32'h100 + W'(i), 0, 0, p, a, e);
      for (int i = 0; i < 3; i++) go(0, 0, 0, 0, p, a, e);
      for (int i = 0; i < 100; i++) begin
         go(1, 32'h200 + W'(i), 1, 0, p, a, e);
         checks++; if (!p || a !== e) $display("FAIL b2b_pop %0d got %b/%h want 1/%h", i, p, a, e); else passes++;
         checks++; if (count !== 8) $display("FAIL b2b_count %0d got %0d want 8", i, count); else passes++;
      end
   endtask

   task automatic test_random();
      logic p, w, r, hold; logic [W-1:0] a, e, d, held_d;
      int pushed = 0;
      hold = 0; held_d = '0;
      for (int c = 0; c < 60000 && pushed < 10000; c++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         d = $urandom;
         if (w && m_q.size() < DEPTH) pushed++;
         hold = re_tvalid & ~r;
         held_d = re_tdata;
         go(w, d, r, 0, p, a, e);
         if (p) begin
            checks++; if (a !== e) $display("FAIL rnd_data got %h want %h", a, e); else passes++;
         end
         if (hold) begin
            checks++; if (re_tvalid !== 1 || re_tdata !== held_d) $display("FAIL rnd_hold got %b/%h want 1/%h", re_tvalid, re_tdata, held_d); else passes++;
         end
         if (m_q.size() == 0) begin
            checks++; if (re_tvalid !== 0) $display("FAIL rnd_empty_tvalid got %b want 0", re_tvalid); else passes++;
         end
         checks++; if (count !== m_q.size()) $display("FAIL rnd_count got %0d want %0d", count, m_q.size()); else passes++;
         checks++; if (almostfull !== (m_q.size() >= DEPTH - M)) $display("FAIL rnd_afull got %b want %b", almostfull, m_q.size() >= DEPTH - M); else passes++;
      end
      checks++; if (pushed !== 10000) $display("FAIL rnd_budget got %0d want 10000", pushed); else passes++;
      for (int c = 0; c < 60; c++) begin
         go(0, 0, 1, 0, p, a, e);
         if (p) begin
            checks++; if (a !== e) $display("FAIL rnd_drain_data got %h want %h", a, e); else passes++;
         end
      end
      checks++; if (count !== 0 || m_q.size() !== 0 || re_tvalid !== 0) $display("FAIL rnd_drain_empty got %0d/%b want 0/0", count, re_tvalid); else passes++;
   endtask

   task automatic test_flush();
      logic p; logic [W-1:0] a, e;
      for (int i = 0; i < 5; i++) go(1, 32'h300 + W'(i), 0, 0, p, a, e);
      for (int i = 0; i < 3; i++) go(0, 0, 0, 0, p, a, e);
      checks++; if (count !== 5 || overflow !== 1) $display("FAIL flush_pre got %0d/%b want 5/1", count, overflow); else passes++;
      go(1, 32'hDEAD, 1, 1, p, a, e);
      checks++; if (count !== 0) $display("FAIL flush_count got %0d want 0", count); else passes++;
      checks++; if (re_tvalid !== 0) $display("FAIL flush_tvalid got %b want 0", re_tvalid); else passes++;
      checks++; if (overflow !== 1) $display("FAIL flush_overflow got %b want 1", overflow); else passes++;
      go(1, 32'h55, 0, 0, p, a, e);
      checks++; if (re_tvalid !== 0 || count !== 1) $display("FAIL flush_t2 got %b/%0d want 0/1", re_tvalid, count); else passes++;
      go(0, 0, 0, 0, p, a, e);
      checks++; if (re_tvalid !== 1 || re_tdata !== 32'h55) $display("FAIL flush_t3 got %b/%h want 1/55", re_tvalid, re_tdata); else passes++;
      go(0, 0, 1, 0, p, a, e);
      checks++; if (!p || a !== e) $display("FAIL flush_pop got %b/%h want 1/%h", p, a, e); else passes++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_latency();
      test_fill();
      test_drain();
      test_back_to_back();
      test_random();
      test_flush();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
